// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the 7-segment scan driver.
// Segment vectors are declared [0:6] so that bit 0 is segment a and bit 6 is
// segment g; a literal such as 7'b000_0001 therefore reads left to right as a..g.
// All patterns are active-low (0 lights the segment).
package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_ZERO  = 7'b000_0001;
    localparam seg_t SEG_ONE   = 7'b100_1111;
    localparam seg_t SEG_TWO   = 7'b001_0010;
    localparam seg_t SEG_THREE = 7'b000_0110;
    localparam seg_t SEG_FOUR  = 7'b100_1100;
    localparam seg_t SEG_FIVE  = 7'b010_0100;
    localparam seg_t SEG_SIX   = 7'b010_0000;
    localparam seg_t SEG_SEVEN = 7'b000_1111;
    localparam seg_t SEG_EIGHT = 7'b000_0000;
    localparam seg_t SEG_NINE  = 7'b000_0100;
    localparam seg_t SEG_BLANK = 7'b111_1111;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the score/timer logic (master) and the scan driver (slave),
// carrying the display data inputs and the board-pin outputs.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    import seg7_pkg::*;

    logic [4*NUM_DIGITS-1:0] bcd_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lz_en;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg;
    logic                    dp;
    logic                    scan_tick;

    modport master (
        output bcd_in, dp_in, load, lz_en,
        input  an, seg, dp, scan_tick
    );

    modport slave (
        input  bcd_in, dp_in, load, lz_en,
        output an, seg, dp, scan_tick
    );

endinterface

// File: rtl/seg7_scan_driver_decode.sv
// BCD to active-low 7-segment decoder. Codes above 9, or an asserted blank
// input, produce an all-off pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output seg_t       o_seg
);

    // Pattern lookup; blank overrides the digit value.
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_ZERO;
                4'd1:    o_seg = SEG_ONE;
                4'd2:    o_seg = SEG_TWO;
                4'd3:    o_seg = SEG_THREE;
                4'd4:    o_seg = SEG_FOUR;
                4'd5:    o_seg = SEG_FIVE;
                4'd6:    o_seg = SEG_SIX;
                4'd7:    o_seg = SEG_SEVEN;
                4'd8:    o_seg = SEG_EIGHT;
                4'd9:    o_seg = SEG_NINE;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver.
// Holds a shadow copy of the BCD value and decimal points, scans one digit per
// REFRESH_DIV clocks and registers an/seg/dp from the current index.
// Optional macro SEG7_GUARD_EN: blanks all anodes for the first GUARD_CYCLES
// divider counts of every digit slot to suppress ghosting.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    seg7_scan_driver_if.slave       bus
);

    localparam int unsigned DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
`ifdef SEG7_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic [4*NUM_DIGITS-1:0] r_bcd;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_tick;
    logic [NUM_DIGITS-1:0]   r_an;
    seg_t                    r_seg;
    logic                    r_dp_n;

    logic                    w_adv;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic                    w_upper_zero;
    logic [3:0]              w_digit;
    logic                    w_blank;
    seg_t                    w_seg;
    logic                    w_guard;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_adv = (r_div == DIV_LAST);

    // Shadow registers: capture the display value on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bcd <= '0;
            r_dp  <= '0;
        end else if (bus.load) begin
            r_bcd <= bus.bcd_in;
            r_dp  <= bus.dp_in;
        end
    end

    // Refresh divider, digit index and frame-wrap pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_idx  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_adv && (r_idx == IDX_LAST);
            if (w_adv) begin
                r_div <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    // Leading-zero mask: digit i is suppressible when it and every digit above
    // it are zero. Digit 0 always displays.
    always_comb begin
        w_lz_mask    = '0;
        w_upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_upper_zero = w_upper_zero & (r_bcd[4*i +: 4] == 4'd0);
            if (i != 0) begin
                w_lz_mask[i] = w_upper_zero;
            end
        end
    end

    // Digit mux, blanking and anode select for the current index.
    always_comb begin
        w_digit   = r_bcd[{r_idx, 2'b00} +: 4];
        w_blank   = bus.lz_en & w_lz_mask[r_idx];
        w_guard   = GUARD_EN && (32'(r_div) < GUARD_CYCLES);
        w_an_next = w_guard ? '1 : ~(NUM_DIGITS'(1) << r_idx);
    end

    seg7_decode u_decode (
        .i_bcd   (w_digit),
        .i_blank (w_blank),
        .o_seg   (w_seg)
    );

    // Registered pin outputs, one cycle behind the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an   <= '1;
            r_seg  <= SEG_BLANK;
            r_dp_n <= 1'b1;
        end else begin
            r_an   <= w_an_next;
            r_seg  <= w_seg;
            r_dp_n <= ~r_dp[r_idx];
        end
    end

    assign bus.an        = r_an;
    assign bus.seg       = r_seg;
    assign bus.dp        = r_dp_n;
    assign bus.scan_tick = r_tick;

endmodule
